// File: rtl/digit_scan_sequencer.sv
// Time-multiplexed digit scanner driving a 2-to-4 decoder's select and enable.
// Each enabled digit is lit for TICKS_ON cycles, then blanked for TICKS_BLANK cycles.
module digit_scan_sequencer #(
    parameter int unsigned TICKS_ON    = 4,
    parameter int unsigned TICKS_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] digit_mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       frame_done
);

    localparam int unsigned CNT_MAX = (TICKS_ON > TICKS_BLANK) ? TICKS_ON : TICKS_BLANK;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BLANK_N = (TICKS_BLANK > 0) ? TICKS_BLANK - 1 : 0;
    localparam logic [CW-1:0] ON_LAST    = CW'(TICKS_ON - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      nxt_q, nxt_d;
    logic [1:0]      sel_d;
    logic            en_d;
    logic            frame_done_d;
    logic [1:0]      first_c;
    logic [1:0]      search_c;
    logic            stop_c;

    // Lowest set bit of the mask; 0 when the mask is empty.
    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Circular search for the next participating digit after cur (cur itself last).
    function automatic logic [1:0] next_after(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && mask[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign first_c  = lowest_set(digit_mask);
    assign search_c = next_after(digit_mask, sel);
    assign stop_c   = !run || (digit_mask == 4'd0);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nxt_d        = nxt_q;
        sel_d        = sel;
        en_d         = en;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                en_d = 1'b0;
                if (run && (digit_mask != 4'd0)) begin
                    sel_d   = first_c;
                    state_d = S_ON;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end
            end

            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (stop_c) begin
                        state_d      = S_IDLE;
                        en_d         = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        // A search result at or below the current digit means the frame wrapped.
                        frame_done_d = (search_c <= sel);
                        if (TICKS_BLANK == 0) begin
                            sel_d = search_c;
                            en_d  = 1'b1;
                        end else begin
                            state_d = S_BLANK;
                            en_d    = 1'b0;
                            nxt_d   = search_c;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    sel_d   = nxt_q;
                    state_d = S_ON;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            nxt_q      <= 2'd0;
            sel        <= 2'd0;
            en         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nxt_q      <= nxt_d;
            sel        <= sel_d;
            en         <= en_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Scoreboard bench for digit_scan_sequencer: defaults and a zero-blank build run side by side.
module tb_digit_scan_sequencer;

    localparam int TON    = 4;
    localparam int TBLANK = 1;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] digit_mask;
    logic [1:0] sel0, sel1;
    logic       en0, en1;
    logic       fd0, fd1;

    digit_scan_sequencer #(.TICKS_ON(TON), .TICKS_BLANK(TBLANK)) dut0 (
        .clk(clk), .rst(rst), .run(run), .digit_mask(digit_mask),
        .sel(sel0), .en(en0), .frame_done(fd0)
    );

    digit_scan_sequencer #(.TICKS_ON(TON), .TICKS_BLANK(0)) dut1 (
        .clk(clk), .rst(rst), .run(run), .digit_mask(digit_mask),
        .sel(sel1), .en(en1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       fd;
    } exp_t;

    // Behavioural model: mode 0 idle, 1 lit, 2 blanked; left = cycles remaining in phase.
    typedef struct {
        int mode;
        int sel;
        int left;
        int nxt;
        bit fd;
    } mdl_t;

    exp_t q0[$];
    exp_t q1[$];
    mdl_t m0, m1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    function automatic int circ_next(input logic [3:0] mask, input int cur);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int ton, input int tblank,
                                  input bit r, input bit rn, input logic [3:0] mask);
        mdl_t n;
        int   nx;
        n    = m;
        n.fd = 1'b0;
        if (r) begin
            n.mode = 0; n.sel = 0; n.left = 0; n.nxt = 0;
            return n;
        end
        case (m.mode)
            0: if (rn && mask != 4'd0) begin
                   n.mode = 1;
                   n.sel  = circ_next(mask, 3);
                   n.left = ton;
               end
            1: if (m.left == 1) begin
                   if (!rn || mask == 4'd0) begin
                       n.mode = 0;
                       n.fd   = 1'b1;
                   end else begin
                       nx   = circ_next(mask, m.sel);
                       n.fd = (nx <= m.sel);
                       if (tblank == 0) begin
                           n.sel  = nx;
                           n.left = ton;
                       end else begin
                           n.mode = 2;
                           n.nxt  = nx;
                           n.left = tblank;
                       end
                   end
               end else begin
                   n.left = m.left - 1;
               end
            default: if (m.left == 1) begin
                   n.mode = 1;
                   n.sel  = m.nxt;
                   n.left = ton;
               end else begin
                   n.left = m.left - 1;
               end
        endcase
        return n;
    endfunction

    function automatic exp_t to_exp(input mdl_t m);
        exp_t e;
        e.sel = 2'(m.sel);
        e.en  = (m.mode == 1);
        e.fd  = m.fd;
        return e;
    endfunction

    // Apply inputs for the coming edge and queue the outputs expected after it.
    task automatic drive(input bit r, input bit rn, input logic [3:0] mask);
        rst        = r;
        run        = rn;
        digit_mask = mask;
        m0 = step(m0, TON, TBLANK, r, rn, mask);
        m1 = step(m1, TON, 0, r, rn, mask);
        q0.push_back(to_exp(m0));
        q1.push_back(to_exp(m1));
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; sample on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            tests++;
            if (sel0 !== e.sel || en0 !== e.en || fd0 !== e.fd) begin
                fails++;
                $display("FAIL blank1 cyc=%0d got sel=%0d en=%0b fd=%0b expected sel=%0d en=%0b fd=%0b",
                         cyc, sel0, en0, fd0, e.sel, e.en, e.fd);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            tests++;
            if (sel1 !== e.sel || en1 !== e.en || fd1 !== e.fd) begin
                fails++;
                $display("FAIL blank0 cyc=%0d got sel=%0d en=%0b fd=%0b expected sel=%0d en=%0b fd=%0b",
                         cyc, sel1, en1, fd1, e.sel, e.en, e.fd);
            end
        end
    end

    initial begin
        int guard;
        m0 = '{mode: 0, sel: 0, left: 0, nxt: 0, fd: 1'b0};
        m1 = m0;
        rst = 1'b1; run = 1'b1; digit_mask = 4'hF;

        // Reset held with run active, then full scan with all digits.
        repeat (3) drive(1'b1, 1'b1, 4'b1111);
        repeat (45) drive(1'b0, 1'b1, 4'b1111);

        // Sparse and single-digit masks.
        repeat (32) drive(1'b0, 1'b1, 4'b1010);
        repeat (22) drive(1'b0, 1'b1, 4'b0100);

        // Stop during digit 1's second lit cycle.
        drive(1'b1, 1'b1, 4'b1111);
        guard = 0;
        while (!(m0.mode == 1 && m0.sel == 1 && m0.left == TON - 1) && guard < 50) begin
            drive(1'b0, 1'b1, 4'b1111);
            guard++;
        end
        tests++;
        if (guard >= 50) begin
            fails++;
            $display("FAIL stop_setup got timeout after %0d cycles required digit 1 lit", guard);
        end
        repeat (10) drive(1'b0, 1'b0, 4'b1111);

        // Run with an empty mask never lights anything.
        repeat (20) drive(1'b0, 1'b1, 4'b0000);

        // Reset asserted in the middle of a blanking gap.
        guard = 0;
        drive(1'b0, 1'b1, 4'b1111);
        while (m0.mode != 2 && guard < 50) begin
            drive(1'b0, 1'b1, 4'b1111);
            guard++;
        end
        tests++;
        if (guard >= 50) begin
            fails++;
            $display("FAIL blank_setup got timeout after %0d cycles required blank phase", guard);
        end
        drive(1'b1, 1'b1, 4'b1111);
        repeat (12) drive(1'b0, 1'b1, 4'b1111);

        // Randomised run, mask and occasional reset.
        begin
            logic [3:0] mask;
            mask = 4'hF;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
                drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, mask);
            end
        end

        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d/%0d entries left required 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_scan_sequencer.md
Name: digit_scan_sequencer

Overview:
Time-multiplexing sequencer that drives the 2-to-4 binary decoder's select and enable inputs. It steps through up to four display digits or rows. Each selected digit is held enabled for a programmable on-time, followed by a blanking gap with the decoder disabled, which prevents ghosting. Digits can be masked out, and a pulse marks the end of each full scan frame.

Parameters:
TICKS_ON, 4, clock cycles en is held high per digit (legal range >= 1)
TICKS_BLANK, 1, clock cycles en is held low between digits (legal range >= 0; 0 means no gap)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
run  input  1  scan enable; sampled in IDLE and on the last ON cycle
digit_mask  input  4  bit i = 1 means digit i takes part in the scan
sel  output  2  digit index to the decoder's in port; registered
en  output  1  decoder enable; registered
frame_done  output  1  registered one-cycle pulse at the end of a scan frame

Behaviour:
- Reset (rst = 1 at an edge): state IDLE, sel = 0, en = 0, frame_done = 0, tick counter = 0. Reset overrides all other inputs, including mid-ON and mid-BLANK.
- States: IDLE, ON, BLANK. en = 1 only in ON.
- IDLE:
  - If run = 1 and digit_mask != 0 at an edge: sel <= lowest set bit of digit_mask, state <= ON, counter <= 0.
  - en rises on the cycle after run is sampled (1-cycle latency).
  - Otherwise remain in IDLE with sel held.
- ON:
  - Lasts exactly TICKS_ON cycles; counter counts 0 .. TICKS_ON-1.
  - run and digit_mask are ignored until the last ON cycle (counter = TICKS_ON-1), so the on-time is never truncated.
- On the last ON cycle, compute next = first set bit of digit_mask searching circularly from sel+1, wrapping 3 -> 0. If only sel is set, next = sel. Latch next internally.
- Frame end: frame_done <= 1 for exactly one cycle, the cycle after the last ON cycle, when either:
  - next <= sel (the search wrapped), or
  - the sequencer is stopping (run = 0 or digit_mask = 0).
- Stopping: if run = 0 or digit_mask = 0 on the last ON cycle, state <= IDLE, en <= 0, and sel holds its last value.
- Continuing, TICKS_BLANK > 0: state <= BLANK, en <= 0, sel holds the old digit for all TICKS_BLANK cycles. At the end of BLANK, sel <= latched next, state <= ON, en <= 1.
- Continuing, TICKS_BLANK = 0: go directly ON -> ON with sel <= next. en stays continuously high; sel changes every TICKS_ON cycles.
- Digit period = TICKS_ON + TICKS_BLANK cycles. Full 4-digit frame at defaults = 20 cycles.
- Changing digit_mask in BLANK does not alter the latched next; the new mask takes effect at the next last-ON cycle.
- sel and en always change on the same edge. The decoder never sees en = 1 with a stale sel.
- Counter width is sized to max(TICKS_ON, TICKS_BLANK). No overflow is possible.

Test Plan:
1. Reset: rst = 1 for 3 cycles with run = 1, digit_mask = 4'b1111 -> sel = 0, en = 0, frame_done = 0 every cycle. Release rst -> en = 1 with sel = 0 one cycle later.
2. Full scan, defaults, mask = 4'b1111 -> sel sequence 0,1,2,3,0, each with en high 4 cycles then low 1 cycle. frame_done pulses exactly once per 20 cycles, in the cycle after digit 3's last ON cycle.
3. Sparse mask = 4'b1010 -> sel alternates 1,3,1,3, never 0 or 2 while en = 1. frame_done pulses once every 10 cycles, after digit 3.
4. Single digit, mask = 4'b0100 -> sel stays 2, en pattern 4 high / 1 low. frame_done pulses every 5 cycles.
5. Stop: drop run during digit 1's second ON cycle -> en stays high for the remaining 2 ON cycles, then en = 0, frame_done pulses once, state is IDLE, sel = 1 held. Separately, run = 1 with mask = 0 from IDLE -> en stays 0 indefinitely.
6. Corner cases:
   - rst asserted in the middle of BLANK -> the next cycle shows sel = 0, en = 0, IDLE.
   - Rebuild with TICKS_BLANK = 0, mask = 4'b1111 -> en continuously 1 and sel increments every 4 cycles.
